// File: rtl/bias_rd_ctrl_pkg.sv
// Shared definitions for the bias read controller.
// Holds the default bias word geometry, the width of the per-layer
// group counters, and the controller state encoding.
package bias_rd_ctrl_pkg;

  // Default bias geometry: one word carries 16 lanes of 32 bits.
  localparam int NUM_LANES     = 16;
  localparam int BITWIDTH_DEF  = 32;
  localparam int BANDWIDTH_DEF = NUM_LANES * BITWIDTH_DEF;

  // Width of co_grp_last and of the fetch/release group counters.
  localparam int GRP_W = 11;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/bias_rd_ctrl_buf2.sv
// bias_buf2: two-entry bias holding buffer.
// "cur" is the word presented downstream; "nxt" is the prefetched word
// that slides into cur when cur is released.
// Ports:
//   clk_i, rst_i    clock, asynchronous active-high reset
//   clear_i         drop both entries (data registers keep their value)
//   push_i          write push_data_i into the first free slot
//   push_data_i     incoming bias word
//   pop_i           release cur (ignored while cur is empty)
//   cur_vld_o       cur holds a valid word
//   cur_data_o      cur word; holds its last value while invalid
//   nxt_vld_o       nxt holds a valid word
module bias_buf2 #(
  parameter int LANES  = 16,
  parameter int LANE_W = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    push_i,
  input  logic [LANES*LANE_W-1:0] push_data_i,
  input  logic                    pop_i,
  output logic                    cur_vld_o,
  output logic [LANES*LANE_W-1:0] cur_data_o,
  output logic                    nxt_vld_o
);

  logic [LANES*LANE_W-1:0] cur_q, cur_d;
  logic [LANES*LANE_W-1:0] nxt_q, nxt_d;
  logic                    cur_v_q, cur_v_d;
  logic                    nxt_v_q, nxt_v_d;
  logic                    pop;

  // A push arriving together with a pop of a lone cur entry goes straight
  // into cur, so a just-returned word is visible with no extra cycle.
  always_comb begin
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    cur_v_d = cur_v_q;
    nxt_v_d = nxt_v_q;
    pop     = pop_i && cur_v_q;

    if (pop) begin
      if (nxt_v_q) begin
        cur_d = nxt_q;
        if (push_i) begin
          nxt_d = push_data_i;
        end else begin
          nxt_v_d = 1'b0;
        end
      end else if (push_i) begin
        cur_d = push_data_i;
      end else begin
        cur_v_d = 1'b0;
      end
    end else if (push_i) begin
      if (!cur_v_q) begin
        cur_d   = push_data_i;
        cur_v_d = 1'b1;
      end else begin
        nxt_d   = push_data_i;
        nxt_v_d = 1'b1;
      end
    end

    if (clear_i) begin
      cur_v_d = 1'b0;
      nxt_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cur_q   <= '0;
      nxt_q   <= '0;
      cur_v_q <= 1'b0;
      nxt_v_q <= 1'b0;
    end else begin
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
      cur_v_q <= cur_v_d;
      nxt_v_q <= nxt_v_d;
    end
  end

  assign cur_vld_o  = cur_v_q;
  assign cur_data_o = cur_q;
  assign nxt_vld_o  = nxt_v_q;

endmodule

// File: rtl/bias_rd_ctrl.sv
// bias_rd_ctrl: fetches one bias word per output-channel group from the
// bias FIFO and presents it to the accumulator until grp_done releases it.
// Keeps at most two words in flight (cur + nxt, counting an outstanding
// read) so the next group's bias is ready with no bubble.
// Ports:
//   clk_data       clock
//   rst            asynchronous active-high reset
//   layer_start    one-cycle layer start pulse (ignored while running)
//   co_grp_last    groups-1 for the layer, latched on layer_start
//   fifo_empty     bias FIFO empty flag
//   fifo_rd_en     bias FIFO read strobe
//   fifo_rd_data   FIFO data, valid one cycle after fifo_rd_en
//   grp_done       accumulator releases the current bias word
//   bias_vld       bias_data holds the current group's bias
//   bias_data      current group bias word
//   layer_done     one-cycle pulse after the last group is released
//   err_underflow  sticky: grp_done seen while bias_vld was low
module bias_rd_ctrl
  import bias_rd_ctrl_pkg::*;
#(
  parameter int BANDWIDTH = BANDWIDTH_DEF,
  parameter int BITWIDTH  = BITWIDTH_DEF
) (
  input  logic                 clk_data,
  input  logic                 rst,
  input  logic                 layer_start,
  input  logic [GRP_W-1:0]     co_grp_last,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic [BANDWIDTH-1:0] fifo_rd_data,
  input  logic                 grp_done,
  output logic                 bias_vld,
  output logic [BANDWIDTH-1:0] bias_data,
  output logic                 layer_done,
  output logic                 err_underflow
);

  state_t           state_q, state_d;
  logic [GRP_W-1:0] last_q, last_d;
  logic [GRP_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic             fetch_done_q, fetch_done_d;
  logic [GRP_W-1:0] rel_cnt_q, rel_cnt_d;
  logic             pend_q, pend_d;
  logic             layer_done_q, layer_done_d;
  logic             err_q, err_d;

  logic             cur_v;
  logic             nxt_v;
  logic             rel_ok;
  logic             layer_end;
  logic             rd_en;
  logic             clear_buf;
  logic [1:0]       occ;

  // fetch_done guards the corner where co_grp_last is all ones and the
  // 11-bit fetch counter would wrap back under the limit.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    fetch_cnt_d  = fetch_cnt_q;
    fetch_done_d = fetch_done_q;
    rel_cnt_d    = rel_cnt_q;
    pend_d       = 1'b0;
    layer_done_d = 1'b0;
    err_d        = err_q;
    rd_en        = 1'b0;
    clear_buf    = 1'b0;
    layer_end    = 1'b0;
    rel_ok       = grp_done && cur_v;

    // Slots in use once this cycle's release is accounted for.
    occ = {1'b0, cur_v} + {1'b0, nxt_v} + {1'b0, pend_q} - {1'b0, rel_ok};

    if (grp_done && !cur_v) begin
      err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (layer_start) begin
          state_d      = RUN;
          last_d       = co_grp_last;
          fetch_cnt_d  = '0;
          fetch_done_d = 1'b0;
          rel_cnt_d    = '0;
          clear_buf    = 1'b1;
        end
      end
      RUN: begin
        if (rel_ok) begin
          rel_cnt_d = rel_cnt_q + 1'b1;
          if (rel_cnt_q == last_q) begin
            layer_end    = 1'b1;
            state_d      = IDLE;
            layer_done_d = 1'b1;
            clear_buf    = 1'b1;
          end
        end
        if (!layer_end && !fifo_empty && !fetch_done_q &&
            (fetch_cnt_q <= last_q) && (occ < 2'd2)) begin
          rd_en       = 1'b1;
          pend_d      = 1'b1;
          fetch_cnt_d = fetch_cnt_q + 1'b1;
          if (fetch_cnt_q == last_q) begin
            fetch_done_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_data or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_q       <= '0;
      fetch_cnt_q  <= '0;
      fetch_done_q <= 1'b0;
      rel_cnt_q    <= '0;
      pend_q       <= 1'b0;
      layer_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      fetch_cnt_q  <= fetch_cnt_d;
      fetch_done_q <= fetch_done_d;
      rel_cnt_q    <= rel_cnt_d;
      pend_q       <= pend_d;
      layer_done_q <= layer_done_d;
      err_q        <= err_d;
    end
  end

  // Read data is captured only while a read is pending, so a word that
  // returns after a reset has nowhere to go.
  bias_buf2 #(
    .LANES  (BANDWIDTH / BITWIDTH),
    .LANE_W (BITWIDTH)
  ) u_buf (
    .clk_i       (clk_data),
    .rst_i       (rst),
    .clear_i     (clear_buf),
    .push_i      (pend_q),
    .push_data_i (fifo_rd_data),
    .pop_i       (rel_ok),
    .cur_vld_o   (cur_v),
    .cur_data_o  (bias_data),
    .nxt_vld_o   (nxt_v)
  );

  assign fifo_rd_en    = rd_en;
  assign bias_vld      = cur_v;
  assign layer_done    = layer_done_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_bias_rd_ctrl.sv
// Self-checking bench for bias_rd_ctrl: a behavioural bias FIFO feeds the
// DUT, every word loaded is pushed onto a scoreboard queue, and each word
// presented on bias_data is compared against the queue head when released.
module tb_bias_rd_ctrl;

  localparam int BW = 512;

  logic          clk_data;
  logic          rst;
  logic          layer_start;
  logic [10:0]   co_grp_last;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [BW-1:0] fifo_rd_data;
  logic          grp_done;
  logic          bias_vld;
  logic [BW-1:0] bias_data;
  logic          layer_done;
  logic          err_underflow;

  int total;
  int bad;

  logic [BW-1:0] expQ[$];
  logic [BW-1:0] mem[0:255];
  int pushedCnt;
  int poppedCnt;
  int readCnt;
  int rdEmptyCnt;

  typedef struct {
    int last;
    int gap;
    bit zeros;
    bit chkBubble;
    int expReads;
  } layerVec_t;

  layerVec_t vecs[6];

  bias_rd_ctrl dut (
    .clk_data      (clk_data),
    .rst           (rst),
    .layer_start   (layer_start),
    .co_grp_last   (co_grp_last),
    .fifo_empty    (fifo_empty),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_rd_data  (fifo_rd_data),
    .grp_done      (grp_done),
    .bias_vld      (bias_vld),
    .bias_data     (bias_data),
    .layer_done    (layer_done),
    .err_underflow (err_underflow)
  );

  // Free-running 100 MHz clock.
  initial clk_data = 1'b0;
  always #5 clk_data = ~clk_data;

  assign fifo_empty = (pushedCnt == poppedCnt);

  // Behavioural FIFO: a read returns the head word on the following cycle.
  // Also counts reads and any read attempted against an empty FIFO.
  always @(posedge clk_data) begin
    if (fifo_rd_en) begin
      readCnt <= readCnt + 1;
      if (pushedCnt != poppedCnt) begin
        fifo_rd_data <= mem[poppedCnt % 256];
        poppedCnt    <= poppedCnt + 1;
      end else begin
        rdEmptyCnt <= rdEmptyCnt + 1;
      end
    end
  end

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [BW-1:0] act,
                             input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then drop the pulse-type inputs.
  task automatic applyStimulus(input logic ls, input logic [10:0] last,
                               input logic gd);
    layer_start = ls;
    co_grp_last = last;
    grp_done    = gd;
    @(negedge clk_data);
    layer_start = 1'b0;
    grp_done    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, co_grp_last, 1'b0);
  endtask

  function automatic logic [BW-1:0] randWord();
    logic [BW-1:0] w;
    for (int l = 0; l < 16; l++) w[l*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic pushWord(input logic [BW-1:0] w);
    mem[pushedCnt % 256] = w;
    pushedCnt++;
    expQ.push_back(w);
  endtask

  task automatic waitVld(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bias_vld === 1'b1) begin
        ok = 1'b1;
        break;
      end
      idle(1);
    end
    if (!ok) begin
      total++;
      bad++;
      $display("[TB] FAIL waitVld: got bias_vld=0 for 40 cycles want 1");
    end
  endtask

  // Serve last+1 groups: check each word against the scoreboard, hold it
  // for gap cycles, release it, and check the follow-up cycle.
  task automatic runGroups(input int last, input int gap, input bit chkBubble,
                           input string tag);
    bit ok;
    logic [BW-1:0] exp;
    for (int g = 0; g <= last; g++) begin
      waitVld(ok);
      if (!ok) return;
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL %s.sb: got empty scoreboard want word", tag);
        return;
      end
      exp = expQ.pop_front();
      checkOutput({tag, ".data"}, bias_data, exp);
      idle(gap);
      applyStimulus(1'b0, co_grp_last, 1'b1);
      if (g < last) begin
        checkOutput({tag, ".noDone"}, BW'(layer_done), BW'(0));
        if (chkBubble) checkOutput({tag, ".bubble"}, BW'(bias_vld), BW'(1));
      end else begin
        checkOutput({tag, ".done"}, BW'(layer_done), BW'(1));
        checkOutput({tag, ".vldOff"}, BW'(bias_vld), BW'(0));
        idle(1);
        checkOutput({tag, ".doneOff"}, BW'(layer_done), BW'(0));
      end
    end
  endtask

  task automatic runLayer(input layerVec_t v, input string tag);
    int n;
    int r0;
    n = v.last + 1 - expQ.size();
    for (int i = 0; i < n; i++) pushWord(v.zeros ? '0 : randWord());
    r0 = readCnt;
    applyStimulus(1'b1, 11'(v.last), 1'b0);
    runGroups(v.last, v.gap, v.chkBubble, tag);
    checkOutput({tag, ".reads"}, BW'(readCnt - r0), BW'(v.expReads));
  endtask

  // Main sequence: reset, single-group layer, table of layers, then the
  // empty-FIFO/underflow, ignored-restart and mid-layer reset cases.
  initial begin
    int r0;
    int errs;
    logic [BW-1:0] exp;

    vecs[0] = '{last: 3, gap: 4, zeros: 1'b0, chkBubble: 1'b1, expReads: 4};
    vecs[1] = '{last: 1, gap: 1, zeros: 1'b0, chkBubble: 1'b1, expReads: 2};
    vecs[2] = '{last: 5, gap: 2, zeros: 1'b0, chkBubble: 1'b1, expReads: 6};
    vecs[3] = '{last: 2, gap: 3, zeros: 1'b1, chkBubble: 1'b1, expReads: 3};
    vecs[4] = '{last: 4, gap: 0, zeros: 1'b0, chkBubble: 1'b1, expReads: 5};
    vecs[5] = '{last: 0, gap: 1, zeros: 1'b0, chkBubble: 1'b0, expReads: 1};

    total = 0;
    bad = 0;
    pushedCnt = 0;
    poppedCnt = 0;
    readCnt = 0;
    rdEmptyCnt = 0;
    fifo_rd_data = '0;
    rst = 1'b1;
    layer_start = 1'b0;
    co_grp_last = '0;
    grp_done = 1'b0;

    repeat (3) @(negedge clk_data);
    checkOutput("rst.rdEn", BW'(fifo_rd_en), BW'(0));
    checkOutput("rst.vld", BW'(bias_vld), BW'(0));
    checkOutput("rst.data", bias_data, BW'(0));
    checkOutput("rst.done", BW'(layer_done), BW'(0));
    checkOutput("rst.err", BW'(err_underflow), BW'(0));
    rst = 1'b0;
    idle(2);

    // Single group: read at cycle 1, bias valid at cycle 3.
    pushWord({64{8'hA5}});
    r0 = readCnt;
    applyStimulus(1'b1, 11'd0, 1'b0);
    checkOutput("s34.rdEnC1", BW'(fifo_rd_en), BW'(1));
    checkOutput("s34.vldC1", BW'(bias_vld), BW'(0));
    idle(1);
    checkOutput("s34.vldC2", BW'(bias_vld), BW'(0));
    idle(1);
    checkOutput("s34.vldC3", BW'(bias_vld), BW'(1));
    exp = expQ.pop_front();
    checkOutput("s34.data", bias_data, exp);
    applyStimulus(1'b0, 11'd0, 1'b1);
    checkOutput("s34.done", BW'(layer_done), BW'(1));
    checkOutput("s34.vldOff", BW'(bias_vld), BW'(0));
    checkOutput("s34.holdData", bias_data, exp);
    pushWord(randWord());
    errs = 0;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      if (fifo_rd_en !== 1'b0) errs++;
    end
    checkOutput("s34.idleNoRead", BW'(errs), BW'(0));
    checkOutput("s34.reads", BW'(readCnt - r0), BW'(1));

    for (int i = 0; i < 6; i++) begin
      runLayer(vecs[i], $sformatf("vec%0d", i));
    end

    // Empty FIFO after layer_start, with a stray grp_done in the middle.
    r0 = readCnt;
    applyStimulus(1'b1, 11'd1, 1'b0);
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) applyStimulus(1'b0, 11'd1, 1'b1);
      else idle(1);
      if (fifo_rd_en !== 1'b0 || bias_vld !== 1'b0) errs++;
    end
    checkOutput("s36.quiet", BW'(errs), BW'(0));
    checkOutput("s37.err", BW'(err_underflow), BW'(1));
    pushWord(randWord());
    pushWord(randWord());
    runGroups(1, 2, 1'b1, "s36");
    checkOutput("s36.reads", BW'(readCnt - r0), BW'(2));
    checkOutput("s37.sticky", BW'(err_underflow), BW'(1));

    // layer_start while running must not change the latched group count.
    for (int i = 0; i < 3; i++) pushWord(randWord());
    r0 = readCnt;
    applyStimulus(1'b1, 11'd2, 1'b0);
    idle(4);
    applyStimulus(1'b1, 11'd7, 1'b0);
    runGroups(2, 3, 1'b1, "s39");
    checkOutput("s39.reads", BW'(readCnt - r0), BW'(3));

    // Reset while a read is outstanding; the returning word is dropped.
    pushWord(randWord());
    r0 = readCnt;
    applyStimulus(1'b1, 11'd0, 1'b0);
    checkOutput("s38.rdEn", BW'(fifo_rd_en), BW'(1));
    idle(1);
    rst = 1'b1;
    @(negedge clk_data);
    checkOutput("s38.rdEn0", BW'(fifo_rd_en), BW'(0));
    checkOutput("s38.vld0", BW'(bias_vld), BW'(0));
    checkOutput("s38.data0", bias_data, BW'(0));
    checkOutput("s38.done0", BW'(layer_done), BW'(0));
    checkOutput("s38.err0", BW'(err_underflow), BW'(0));
    rst = 1'b0;
    void'(expQ.pop_front());
    idle(4);
    checkOutput("s38.noCapVld", BW'(bias_vld), BW'(0));
    checkOutput("s38.noCapData", bias_data, BW'(0));
    pushWord(randWord());
    errs = 0;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      if (fifo_rd_en !== 1'b0) errs++;
    end
    checkOutput("s38.noRead", BW'(errs), BW'(0));
    checkOutput("s38.reads", BW'(readCnt - r0), BW'(1));
    runLayer(vecs[5], "post");

    checkOutput("rdWhileEmpty", BW'(rdEmptyCnt), BW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
